// File: rtl/mips_muldiv_if.sv
// Handshake and HI/LO bus between the EX stage and the iterative multiply/divide unit.
// The master is the pipeline side and the slave is the muldiv unit.
interface mips_muldiv_if #(parameter int WIDTH = 32);
   logic             start_i;
   logic [1:0]       op_i;
   logic [WIDTH-1:0] rs_data_i;
   logic [WIDTH-1:0] rt_data_i;
   logic             flush_i;
   logic             hi_we_i;
   logic             lo_we_i;
   logic [WIDTH-1:0] wdata_i;
   logic             busy_o;
   logic             done_o;
   logic [WIDTH-1:0] hi_o;
   logic [WIDTH-1:0] lo_o;

   modport master (
      output start_i, op_i, rs_data_i, rt_data_i, flush_i, hi_we_i, lo_we_i, wdata_i,
      input  busy_o, done_o, hi_o, lo_o
   );

   modport slave (
      input  start_i, op_i, rs_data_i, rt_data_i, flush_i, hi_we_i, lo_we_i, wdata_i,
      output busy_o, done_o, hi_o, lo_o
   );
endinterface

// File: rtl/mips_muldiv.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit that owns the architectural HI/LO registers.
// It works on operand magnitudes and applies the sign correction only when the result is committed.
module mips_muldiv #(
   parameter int WIDTH = 32
) (
   input logic          clk,
   input logic          rst,
   mips_muldiv_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state, state_next;
   logic [CW-1:0]    counter;
   logic [WIDTH-1:0] acc_hi, acc_lo, mag_b, raw_rs, hi_q, lo_q;
   logic             is_div, neg_res, neg_rem, div_zero, done_q;
   logic             accept, finish;
   logic             signed_op, rs_neg, rt_neg;
   logic [WIDTH:0]   add_sum, div_shift, div_diff;
   logic [WIDTH-1:0] step_hi, step_lo, res_hi, res_lo;
   logic [2*WIDTH-1:0] prod_fix;

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start_i && !bus.flush_i) begin
               accept     = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            // A flush on the last step wins, so the result is thrown away.
            if (bus.flush_i) begin
               state_next = IDLE;
            end else if (counter == LAST) begin
               finish     = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // The shift-add multiply and the restoring divide share acc_hi/acc_lo. One step runs per cycle.
   always_comb begin
      signed_op = ~bus.op_i[0];
      rs_neg    = signed_op & bus.rs_data_i[WIDTH-1];
      rt_neg    = signed_op & bus.rt_data_i[WIDTH-1];
      add_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);
      div_shift = {acc_hi, acc_lo[WIDTH-1]};
      div_diff  = div_shift - {1'b0, mag_b};
      if (is_div) begin
         if (!div_diff[WIDTH]) begin
            step_hi = div_diff[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], 1'b1};
         end else begin
            step_hi = div_shift[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], 1'b0};
         end
      end else begin
         step_hi = add_sum[WIDTH:1];
         step_lo = {add_sum[0], acc_lo[WIDTH-1:1]};
      end
   end

   always_comb begin
      prod_fix = neg_res ? -{step_hi, step_lo} : {step_hi, step_lo};
      if (div_zero && is_div) begin
         res_hi = raw_rs;
         res_lo = '1;
      end else if (is_div) begin
         res_hi = neg_rem ? -step_hi : step_hi;
         res_lo = neg_res ? -step_lo : step_lo;
      end else begin
         res_hi = prod_fix[2*WIDTH-1:WIDTH];
         res_lo = prod_fix[WIDTH-1:0];
      end
   end

   // Operand latching, the iteration step, commits to HI/LO and the done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         counter  <= '0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         mag_b    <= '0;
         raw_rs   <= '0;
         is_div   <= 1'b0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         div_zero <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= finish;
         if (state == IDLE) begin
            if (bus.hi_we_i) hi_q <= bus.wdata_i;
            if (bus.lo_we_i) lo_q <= bus.wdata_i;
            if (accept) begin
               counter  <= '0;
               acc_hi   <= '0;
               acc_lo   <= rs_neg ? -bus.rs_data_i : bus.rs_data_i;
               mag_b    <= rt_neg ? -bus.rt_data_i : bus.rt_data_i;
               raw_rs   <= bus.rs_data_i;
               is_div   <= bus.op_i[1];
               neg_res  <= rs_neg ^ rt_neg;
               neg_rem  <= rs_neg;
               div_zero <= (bus.rt_data_i == '0);
            end
         end else begin
            counter <= counter + CW'(1);
            acc_hi  <= step_hi;
            acc_lo  <= step_lo;
            if (finish) begin
               hi_q <= res_hi;
               lo_q <= res_lo;
            end
         end
      end
   end

   assign bus.busy_o = (state == RUN);
   assign bus.done_o = done_q;
   assign bus.hi_o   = hi_q;
   assign bus.lo_o   = lo_q;
endmodule

// File: tb/tb_mips_muldiv.sv
// Self-checking bench for mips_muldiv: a table of vectors, random ops checked against a 64-bit reference model,
// and hand-written flush, reset, MTHI/MTLO and double-start sequences. Expected results go through a scoreboard queue.
module tb_mips_muldiv;
   localparam int WIDTH = 32;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
   } result_t;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      result_t     exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   n_compared = 0;
   int   n_mismatched = 0;
   result_t sb[$];
   vec_t    vecs[12];

   always #5 clk = ~clk;

   mips_muldiv_if #(.WIDTH(WIDTH)) bus ();
   mips_muldiv #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

   // Every comparison goes through this task so that the counters stay consistent.
   task automatic checkOutput(input string what, input logic [63:0] actual, input logic [63:0] required);
      n_compared++;
      if (actual !== required) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", what, actual, required);
      end
   endtask

   // Reference semantics built from 64-bit arithmetic. SV / and % truncate toward zero.
   function automatic result_t ref_model(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt);
      logic signed [63:0] sa, sbv, p, q, r;
      result_t res;
      sa  = {{32{rs[31]}}, rs};
      sbv = {{32{rt[31]}}, rt};
      if (op[1] && rt == 32'd0) begin
         res.hi = rs;
         res.lo = 32'hFFFF_FFFF;
      end else begin
         case (op)
            2'b00: begin p = sa * sbv; res.hi = p[63:32]; res.lo = p[31:0]; end
            2'b01: begin p = {32'd0, rs} * {32'd0, rt}; res.hi = p[63:32]; res.lo = p[31:0]; end
            2'b10: begin q = sa / sbv; r = sa % sbv; res.hi = r[31:0]; res.lo = q[31:0]; end
            default: begin res.hi = rs % rt; res.lo = rs / rt; end
         endcase
      end
      return res;
   endfunction

   task automatic start_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt);
      @(negedge clk);
      bus.start_i   = 1'b1;
      bus.op_i      = op;
      bus.rs_data_i = rs;
      bus.rt_data_i = rt;
      @(negedge clk);
      bus.start_i = 1'b0;
   endtask

   task automatic applyStimulus(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt, input result_t exp);
      sb.push_back(exp);
      start_op(op, rs, rt);
   endtask

   task automatic check_result(input string tag);
      result_t exp;
      if (sb.size() == 0) begin
         n_compared++;
         n_mismatched++;
         $display("[TB] FAIL %s unexpected_done: got done_o=1, expected no pending result", tag);
      end else begin
         exp = sb.pop_front();
         checkOutput({tag, " hi"}, {32'd0, bus.hi_o}, {32'd0, exp.hi});
         checkOutput({tag, " lo"}, {32'd0, bus.lo_o}, {32'd0, exp.lo});
      end
   endtask

   // Waits for done with a bounded budget and checks the busy length, the result and the single-cycle pulse.
   task automatic run_to_done(input string tag);
      int busy_cycles = 0;
      bit got = 0;
      for (int i = 0; i < WIDTH + 4; i++) begin
         if (bus.done_o) begin
            got = 1;
            break;
         end
         if (bus.busy_o) busy_cycles++;
         @(negedge clk);
      end
      if (!got) begin
         n_compared++;
         n_mismatched++;
         $display("[TB] FAIL %s timeout: got no done_o, expected done within %0d cycles", tag, WIDTH + 4);
         void'(sb.pop_front());
      end else begin
         check_result(tag);
         checkOutput({tag, " busy_len"}, 64'(busy_cycles), 64'(WIDTH));
         @(negedge clk);
         checkOutput({tag, " done_pulse"}, {63'd0, bus.done_o}, 64'd0);
      end
   endtask

   task automatic watch_done(input int cycles, output int dones);
      dones = 0;
      for (int i = 0; i < cycles; i++) begin
         if (bus.done_o) begin
            dones++;
            check_result("watch");
         end
         @(negedge clk);
      end
   endtask

   task automatic mt_write(input logic [31:0] hi, input logic [31:0] lo);
      @(negedge clk);
      bus.hi_we_i = 1'b1;
      bus.wdata_i = hi;
      @(negedge clk);
      bus.hi_we_i = 1'b0;
      bus.lo_we_i = 1'b1;
      bus.wdata_i = lo;
      @(negedge clk);
      bus.lo_we_i = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int dones;
      logic [1:0]  rop;
      logic [31:0] rrs, rrt;

      vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '{32'hFFFF_FFFE, 32'h0000_0001}};
      vecs[1]  = '{2'b00, 32'hFFFF_FFFD, 32'd7,         '{32'hFFFF_FFFF, 32'hFFFF_FFEB}};
      vecs[2]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, '{32'h4000_0000, 32'h0000_0000}};
      vecs[3]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,         '{32'hFFFF_FFFF, 32'hFFFF_FFFD}};
      vecs[4]  = '{2'b11, 32'd100,       32'd7,         '{32'd2,         32'd14}};
      vecs[5]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, '{32'h0000_0000, 32'h8000_0000}};
      vecs[6]  = '{2'b11, 32'd5,         32'd0,         '{32'd5,         32'hFFFF_FFFF}};
      vecs[7]  = '{2'b10, 32'hFFFF_FFF9, 32'd0,         '{32'hFFFF_FFF9, 32'hFFFF_FFFF}};
      vecs[8]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, '{32'd1,         32'hFFFF_FFFD}};
      vecs[9]  = '{2'b00, 32'h8000_0000, 32'd1,         '{32'hFFFF_FFFF, 32'h8000_0000}};
      vecs[10] = '{2'b11, 32'hFFFF_FFFF, 32'd1,         '{32'd0,         32'hFFFF_FFFF}};
      vecs[11] = '{2'b01, 32'd0,         32'd12345,     '{32'd0,         32'd0}};

      bus.start_i = 1'b0; bus.op_i = 2'b00; bus.rs_data_i = '0; bus.rt_data_i = '0;
      bus.flush_i = 1'b0; bus.hi_we_i = 1'b0; bus.lo_we_i = 1'b0; bus.wdata_i = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset busy", {63'd0, bus.busy_o}, 64'd0);
      checkOutput("reset done", {63'd0, bus.done_o}, 64'd0);
      checkOutput("reset hi", {32'd0, bus.hi_o}, 64'd0);
      checkOutput("reset lo", {32'd0, bus.lo_o}, 64'd0);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].exp);
         run_to_done($sformatf("vec%0d", i));
      end

      for (int i = 0; i < 6; i++) begin
         rop = 2'($urandom_range(0, 3));
         rrs = $urandom;
         rrt = (rop[1] && i[0]) ? 32'($urandom_range(1, 20)) : $urandom;
         applyStimulus(rop, rrs, rrt, ref_model(rop, rrs, rrt));
         run_to_done($sformatf("rand%0d", i));
      end

      // MTLO in IDLE shows up on the next cycle. MTHI during RUN is dropped.
      mt_write(32'hAAAA_0000, 32'h0);
      @(negedge clk);
      bus.lo_we_i = 1'b1;
      bus.wdata_i = 32'h0000_1234;
      @(negedge clk);
      bus.lo_we_i = 1'b0;
      checkOutput("mtlo idle", {32'd0, bus.lo_o}, 64'h1234);
      applyStimulus(2'b11, 32'd100, 32'd7, '{32'd2, 32'd14});
      repeat (3) @(negedge clk);
      bus.hi_we_i = 1'b1;
      bus.wdata_i = 32'hDEAD_BEEF;
      @(negedge clk);
      bus.hi_we_i = 1'b0;
      checkOutput("mthi run ignored", {32'd0, bus.hi_o}, 64'hAAAA_0000);
      watch_done(WIDTH + 4, dones);
      checkOutput("mthi run dones", 64'(dones), 64'd1);

      // An MTLO that coincides with an accepted start lands, then the result overwrites it.
      @(negedge clk);
      bus.start_i = 1'b1; bus.op_i = 2'b01; bus.rs_data_i = 32'd2; bus.rt_data_i = 32'd3;
      bus.lo_we_i = 1'b1; bus.wdata_i = 32'h5555;
      sb.push_back('{32'd0, 32'd6});
      @(negedge clk);
      bus.start_i = 1'b0; bus.lo_we_i = 1'b0;
      checkOutput("coincident mtlo", {32'd0, bus.lo_o}, 64'h5555);
      watch_done(WIDTH + 4, dones);
      checkOutput("coincident dones", 64'(dones), 64'd1);

      // A flush at cycle 10 aborts with no done pulse, and HI/LO keep their values.
      mt_write(32'h1111, 32'h2222);
      start_op(2'b11, 32'd1000, 32'd3);
      repeat (9) @(negedge clk);
      bus.flush_i = 1'b1;
      @(negedge clk);
      bus.flush_i = 1'b0;
      checkOutput("flush busy", {63'd0, bus.busy_o}, 64'd0);
      watch_done(WIDTH + 4, dones);
      checkOutput("flush dones", 64'(dones), 64'd0);
      checkOutput("flush hi", {32'd0, bus.hi_o}, 64'h1111);
      checkOutput("flush lo", {32'd0, bus.lo_o}, 64'h2222);

      // A flush on the final step beats the completion.
      start_op(2'b01, 32'd9, 32'd9);
      repeat (WIDTH - 1) @(negedge clk);
      bus.flush_i = 1'b1;
      @(negedge clk);
      bus.flush_i = 1'b0;
      checkOutput("last flush busy", {63'd0, bus.busy_o}, 64'd0);
      watch_done(6, dones);
      checkOutput("last flush dones", 64'(dones), 64'd0);
      checkOutput("last flush lo", {32'd0, bus.lo_o}, 64'h2222);

      // start_i together with flush_i in IDLE is not accepted.
      @(negedge clk);
      bus.start_i = 1'b1; bus.flush_i = 1'b1; bus.op_i = 2'b01;
      @(negedge clk);
      bus.start_i = 1'b0; bus.flush_i = 1'b0;
      checkOutput("start+flush busy", {63'd0, bus.busy_o}, 64'd0);
      watch_done(WIDTH + 2, dones);
      checkOutput("start+flush dones", 64'(dones), 64'd0);

      // A second start during RUN is ignored.
      applyStimulus(2'b01, 32'd3, 32'd5, '{32'd0, 32'd15});
      repeat (4) @(negedge clk);
      bus.start_i = 1'b1; bus.rs_data_i = 32'd100; bus.rt_data_i = 32'd100;
      @(negedge clk);
      bus.start_i = 1'b0;
      watch_done(WIDTH + 8, dones);
      checkOutput("double start dones", 64'(dones), 64'd1);

      // A reset at cycle 20 clears HI/LO and commits nothing.
      start_op(2'b00, 32'd77, 32'd88);
      repeat (19) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("midop reset busy", {63'd0, bus.busy_o}, 64'd0);
      checkOutput("midop reset hi", {32'd0, bus.hi_o}, 64'd0);
      checkOutput("midop reset lo", {32'd0, bus.lo_o}, 64'd0);
      watch_done(WIDTH + 2, dones);
      checkOutput("midop reset dones", 64'(dones), 64'd0);

      checkOutput("scoreboard drained", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end
endmodule
